// File: rtl/tri_port_memory_bank_if.sv
// Bus bundle for the three memory banks (IM, DM, MEM): per-bank select, read/write strobes,
// address, write data and registered read data.
interface tri_port_memory_bank_if #(
    parameter int DATA_W = 32,
    parameter int IM_AW  = 10,
    parameter int DM_AW  = 15,
    parameter int MEM_AW = 14
);
    logic              im_enable;
    logic              im_read;
    logic              im_write;
    logic [IM_AW-1:0]  im_address;
    logic [DATA_W-1:0] im_din;
    logic [DATA_W-1:0] im_dout;

    logic              dm_enable;
    logic              dm_read;
    logic              dm_write;
    logic [DM_AW-1:0]  dm_address;
    logic [DATA_W-1:0] dm_din;
    logic [DATA_W-1:0] dm_dout;

    logic              mem_enable;
    logic              mem_read;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_address;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output im_enable, im_read, im_write, im_address, im_din,
        output dm_enable, dm_read, dm_write, dm_address, dm_din,
        output mem_enable, mem_read, mem_write, mem_address, mem_din,
        input  im_dout, dm_dout, mem_dout
    );

    modport slave (
        input  im_enable, im_read, im_write, im_address, im_din,
        input  dm_enable, dm_read, dm_write, dm_address, dm_din,
        input  mem_enable, mem_read, mem_write, mem_address, mem_din,
        output im_dout, dm_dout, mem_dout
    );
endinterface

// File: rtl/tri_port_memory_bank.sv
// Three independent single-port synchronous RAMs (instruction, data, main memory) with
// registered read data; read-before-write when read and write coincide.
module tri_port_memory_bank #(
    parameter int DATA_W = 32,
    parameter int IM_AW  = 10,
    parameter int DM_AW  = 15,
    parameter int MEM_AW = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    tri_port_memory_bank_if.slave bus
);
    localparam int IM_DEPTH  = 1 << IM_AW;
    localparam int DM_DEPTH  = 1 << DM_AW;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    // Array contents are deliberately never reset so preloaded images survive rst.
    logic [DATA_W-1:0] im_mem_data [0:IM_DEPTH-1];
    logic [DATA_W-1:0] dm_mem_data [0:DM_DEPTH-1];
    logic [DATA_W-1:0] mem_data    [0:MEM_DEPTH-1];

    logic [DATA_W-1:0] im_dout_q,  im_dout_d;
    logic [DATA_W-1:0] dm_dout_q,  dm_dout_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;

    logic im_wr_en;
    logic dm_wr_en;
    logic mem_wr_en;

    // Writes are qualified with rst so an edge seen while reset is held stores nothing.
    always_comb begin
        im_wr_en  = rst & bus.im_enable  & bus.im_write;
        dm_wr_en  = rst & bus.dm_enable  & bus.dm_write;
        mem_wr_en = rst & bus.mem_enable & bus.mem_write;
    end

    always_comb begin
        im_dout_d  = im_dout_q;
        dm_dout_d  = dm_dout_q;
        mem_dout_d = mem_dout_q;
        if (bus.im_enable && bus.im_read) begin
            im_dout_d = im_mem_data[bus.im_address];
        end
        if (bus.dm_enable && bus.dm_read) begin
            dm_dout_d = dm_mem_data[bus.dm_address];
        end
        if (bus.mem_enable && bus.mem_read) begin
            mem_dout_d = mem_data[bus.mem_address];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_dout_q  <= '0;
            dm_dout_q  <= '0;
            mem_dout_q <= '0;
        end else begin
            im_dout_q  <= im_dout_d;
            dm_dout_q  <= dm_dout_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (im_wr_en) begin
            im_mem_data[bus.im_address] <= bus.im_din;
        end
    end

    always_ff @(posedge clk) begin
        if (dm_wr_en) begin
            dm_mem_data[bus.dm_address] <= bus.dm_din;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            mem_data[bus.mem_address] <= bus.mem_din;
        end
    end

    assign bus.im_dout  = im_dout_q;
    assign bus.dm_dout  = dm_dout_q;
    assign bus.mem_dout = mem_dout_q;
endmodule

// File: tb/tb_tri_port_memory_bank.sv
// Directed bench for tri_port_memory_bank: backdoor preloads, per-bank access checks and
// asynchronous reset behaviour, one printed line per comparison.
module tb_tri_port_memory_bank;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    tri_port_memory_bank_if bus ();

    tri_port_memory_bank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic idle();
        bus.im_enable   = 1'b0;
        bus.im_read     = 1'b0;
        bus.im_write    = 1'b0;
        bus.im_address  = '0;
        bus.im_din      = '0;
        bus.dm_enable   = 1'b0;
        bus.dm_read     = 1'b0;
        bus.dm_write    = 1'b0;
        bus.dm_address  = '0;
        bus.dm_din      = '0;
        bus.mem_enable  = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_din     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        #1 rst = 1'b0;

        dut.mem_data[5]       = 32'hDEADBEEF;
        dut.mem_data[0]       = 32'h0BADF00D;
        dut.im_mem_data[0]    = 32'hA5A50000;
        dut.dm_mem_data[3]    = 32'h00000055;
        dut.dm_mem_data[10]   = 32'h00000001;
        dut.dm_mem_data[39]   = 32'h00000000;
        #1;
        check("reset_im_dout",  bus.im_dout,  32'h0);
        check("reset_dm_dout",  bus.dm_dout,  32'h0);
        check("reset_mem_dout", bus.mem_dout, 32'h0);

        repeat (2) tick();
        check("preload_survives_reset", dut.mem_data[5], 32'hDEADBEEF);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // MEM read of preloaded word, then hold with enable low and with a no-op
        bus.mem_enable = 1'b1; bus.mem_read = 1'b1; bus.mem_address = 14'd5;
        tick();
        check("mem_read_5", bus.mem_dout, 32'hDEADBEEF);
        idle();
        tick();
        check("mem_hold_disabled", bus.mem_dout, 32'hDEADBEEF);
        bus.mem_enable = 1'b1;
        tick();
        check("mem_hold_noop", bus.mem_dout, 32'hDEADBEEF);
        idle();

        // IM write then read
        bus.im_enable = 1'b1; bus.im_write = 1'b1; bus.im_address = 10'd128; bus.im_din = 32'h12345678;
        tick();
        check("im_backdoor_128", dut.im_mem_data[128], 32'h12345678);
        bus.im_write = 1'b0; bus.im_read = 1'b1;
        tick();
        check("im_read_128", bus.im_dout, 32'h12345678);
        idle();

        // DM enable gating
        bus.dm_enable = 1'b0; bus.dm_write = 1'b1; bus.dm_address = 15'd3; bus.dm_din = 32'd7;
        tick();
        check("dm_gated_write", dut.dm_mem_data[3], 32'h00000055);
        bus.dm_enable = 1'b1;
        tick();
        check("dm_enabled_write", dut.dm_mem_data[3], 32'd7);
        idle();

        // Read-before-write at the same address
        bus.dm_enable = 1'b1; bus.dm_read = 1'b1; bus.dm_write = 1'b1;
        bus.dm_address = 15'd10; bus.dm_din = 32'd2;
        tick();
        check("dm_rbw_old_data", bus.dm_dout, 32'd1);
        check("dm_rbw_stored",   dut.dm_mem_data[10], 32'd2);
        bus.dm_write = 1'b0;
        tick();
        check("dm_reread_10", bus.dm_dout, 32'd2);
        idle();

        // All three banks in the same cycle
        bus.im_enable  = 1'b1; bus.im_read  = 1'b1; bus.im_address  = 10'd0;
        bus.dm_enable  = 1'b1; bus.dm_write = 1'b1; bus.dm_address  = 15'd39; bus.dm_din = 32'd99;
        bus.mem_enable = 1'b1; bus.mem_read = 1'b1; bus.mem_address = 14'd0;
        tick();
        check("conc_im_dout",  bus.im_dout,  32'hA5A50000);
        check("conc_mem_dout", bus.mem_dout, 32'h0BADF00D);
        check("conc_dm_39",    dut.dm_mem_data[39], 32'd99);
        check("conc_dm_hold",  bus.dm_dout,  32'd2);
        idle();

        // Make all douts nonzero, then assert reset between clock edges
        bus.im_enable  = 1'b1; bus.im_read  = 1'b1; bus.im_address  = 10'd128;
        bus.dm_enable  = 1'b1; bus.dm_read  = 1'b1; bus.dm_address  = 15'd10;
        bus.mem_enable = 1'b1; bus.mem_read = 1'b1; bus.mem_address = 14'd5;
        tick();
        check("pre_rst_im_dout",  bus.im_dout,  32'h12345678);
        check("pre_rst_dm_dout",  bus.dm_dout,  32'd2);
        check("pre_rst_mem_dout", bus.mem_dout, 32'hDEADBEEF);
        #2 rst = 1'b0;
        #1;
        check("async_rst_im_dout",  bus.im_dout,  32'h0);
        check("async_rst_dm_dout",  bus.dm_dout,  32'h0);
        check("async_rst_mem_dout", bus.mem_dout, 32'h0);
        bus.dm_write = 1'b1; bus.dm_din = 32'hFFFFFFFF;
        repeat (2) tick();
        check("in_rst_im_dout",  bus.im_dout,  32'h0);
        check("in_rst_dm_dout",  bus.dm_dout,  32'h0);
        check("in_rst_mem_dout", bus.mem_dout, 32'h0);
        check("in_rst_no_write", dut.dm_mem_data[10], 32'd2);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
